// File: rtl/dmem_dma_pkg.sv
// Shared types for the data-memory DMA initiator: op encodings, FSM states
// and the command range check.
package dmem_dma_pkg;

    typedef enum logic [1:0] {
        OP_FILL = 2'b00,
        OP_COPY = 2'b01,
        OP_SUM  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CRD,
        S_CWR,
        S_SUM,
        S_DONE
    } state_e;

    // Operands are zero-extended to 64 bits, wide enough that base+count never wraps.
    function automatic logic out_of_range(input logic [63:0] base,
                                          input logic [63:0] count,
                                          input logic [63:0] limit);
        return (base + count) > limit;
    endfunction

endpackage

// File: rtl/dmem_dma_addr_gen.sv
// Word index counter for dmem_dma with src/dst address adders and a
// last-word flag.
module dmem_dma_addr_gen
    import dmem_dma_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] src_base,
    input  logic [WIDTH-1:0] dst_base,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] src_addr,
    output logic [WIDTH-1:0] dst_addr,
    output logic             last
);

    logic [LEN_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + LEN_W'(1);
        end
    end

    assign src_addr = src_base + WIDTH'(idx);
    assign dst_addr = dst_base + WIDTH'(idx);
    // len is never zero while the counter is in use, so len-1 cannot wrap here.
    assign last     = (idx == len - LEN_W'(1));

endmodule

// File: rtl/dmem_dma.sv
// Command-driven FILL/COPY/SUM initiator for the single-port data memory.
// SUM is built only when DMEM_DMA_SUM_EN is defined; otherwise op=10 is reserved.
module dmem_dma
    import dmem_dma_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100,
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] fill_val,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] WD,
    output logic             WE,
    input  logic [WIDTH-1:0] RD
);

    state_e           state, state_n;
    logic [WIDTH-1:0] cmd_src, cmd_dst, cmd_fill, buffer;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] src_addr, dst_addr;
    logic             last, accept, cmd_err, op_rsvd, src_bad, dst_bad, idx_inc;

    assign accept = (state == S_IDLE) && start;

`ifdef DMEM_DMA_SUM_EN
    assign op_rsvd = (op == OP_RSVD);
`else
    assign op_rsvd = (op == OP_RSVD) || (op == OP_SUM);
`endif

    assign dst_bad = out_of_range(64'(dst), 64'(len), 64'(DEPTH));
    assign src_bad = out_of_range(64'(src), 64'(len), 64'(DEPTH));
    assign cmd_err = op_rsvd
                   || (((op == OP_FILL) || (op == OP_COPY)) && dst_bad)
                   || (((op == OP_COPY) || (op == OP_SUM))  && src_bad);

    assign idx_inc = (state == S_FILL) || (state == S_CWR) || (state == S_SUM);

    dmem_dma_addr_gen #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk      (CLK),
        .rst      (RST),
        .clr      (state == S_IDLE),
        .inc      (idx_inc),
        .src_base (cmd_src),
        .dst_base (cmd_dst),
        .len      (cmd_len),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last     (last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cmd_src  <= '0;
            cmd_dst  <= '0;
            cmd_fill <= '0;
            cmd_len  <= '0;
            buffer   <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cmd_src  <= src;
                cmd_dst  <= dst;
                cmd_fill <= fill_val;
                cmd_len  <= len;
                err      <= cmd_err;
            end
            if (state == S_CRD) begin
                buffer <= RD;
            end
        end
    end

`ifdef DMEM_DMA_SUM_EN
    logic [WIDTH-1:0] acc;

    always_ff @(posedge CLK) begin
        if (RST || accept) begin
            acc <= '0;
        end else if (state == S_SUM) begin
            acc <= acc + RD;
        end
    end

    assign sum = acc;
`else
    assign sum = '0;
`endif

    always_comb begin
        state_n = state;
        A       = '0;
        WD      = '0;
        WE      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cmd_err || (len == '0)) begin
                        state_n = S_DONE;
                    end else begin
                        case (op)
                            OP_FILL: state_n = S_FILL;
                            OP_COPY: state_n = S_CRD;
                            OP_SUM:  state_n = S_SUM;
                            default: state_n = S_DONE;
                        endcase
                    end
                end
            end
            S_FILL: begin
                A  = dst_addr;
                WD = cmd_fill;
                WE = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_CRD: begin
                A       = src_addr;
                state_n = S_CWR;
            end
            S_CWR: begin
                A       = dst_addr;
                WD      = buffer;
                WE      = 1'b1;
                state_n = last ? S_DONE : S_CRD;
            end
            S_SUM: begin
                A = src_addr;
                if (last) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: directed and random commands against an
// operation-level model of the memory, result and timing.
module tb_dmem_dma;

    localparam int WIDTH = 32;
    localparam int DEPTH = 100;
    localparam int LEN_W = 16;
`ifdef DMEM_DMA_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = '0;
    logic [WIDTH-1:0] src = '0, dst = '0, fill_val = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err, WE;
    logic [WIDTH-1:0] sum, A, WD, RD;

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    dmem_dma #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .op       (op),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sum      (sum),
        .A        (A),
        .WD       (WD),
        .WE       (WE),
        .RD       (RD)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        if (A < 32'(DEPTH)) RD = mem[A[6:0]];
        else                RD = '0;
    end

    always @(posedge CLK) begin
        if (WE && (A < 32'(DEPTH))) mem[A[6:0]] <= WD;
    end

    function automatic logic [6:0] wi(input longint a);
        return 7'(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Operation-level reference: applies the whole command to ref_mem and
    // predicts status, latency and the per-cycle write-enable sequence.
    task automatic model(input logic [1:0] m_op, input logic [31:0] m_src, input logic [31:0] m_dst,
                         input logic [15:0] m_len, input logic [31:0] m_fill,
                         output logic e_err, output logic [31:0] e_sum, output int e_lat,
                         output int e_wes, output logic [31:0] e_pat);
        longint s = longint'(m_src);
        longint d = longint'(m_dst);
        longint l = longint'(m_len);
        bit rsvd = (m_op == 2'd3) || (m_op == 2'd2 && !SUM_EN);
        bit bad  = ((m_op == 2'd0 || m_op == 2'd1) && (d + l > DEPTH)) ||
                   ((m_op == 2'd1 || m_op == 2'd2) && (s + l > DEPTH));
        int cycles = 0;
        e_err = 1'b0; e_sum = '0; e_lat = 1; e_wes = 0; e_pat = '0;
        if (rsvd || bad) begin
            e_err = 1'b1;
        end else if (l != 0) begin
            for (longint k = 0; k < l; k++) begin
                case (m_op)
                    2'd0: ref_mem[wi(d + k)] = m_fill;
                    2'd1: ref_mem[wi(d + k)] = ref_mem[wi(s + k)];
                    default: e_sum = e_sum + ref_mem[wi(s + k)];
                endcase
            end
            cycles = (m_op == 2'd1) ? 2 * int'(l) : int'(l);
            e_lat  = cycles + 1;
            e_wes  = (m_op == 2'd2) ? 0 : int'(l);
            for (int c = 0; c < cycles && c < 32; c++) begin
                e_pat[c] = (m_op == 2'd0) || (m_op == 2'd1 && (c % 2 == 1));
            end
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (mem[wi(k)] !== ref_mem[wi(k)]) bad++;
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    // Called at a falling edge with the DUT idle; the command is sampled at the next rising edge.
    task automatic run_cmd(input logic [1:0] c_op, input logic [31:0] c_src, input logic [31:0] c_dst,
                           input logic [15:0] c_len, input logic [31:0] c_fill, input bit poke);
        logic e_err;
        logic [31:0] e_sum, pat;
        int e_lat, e_wes, k, wes;
        logic [31:0] e_pat;
        bit seen;
        model(c_op, c_src, c_dst, c_len, c_fill, e_err, e_sum, e_lat, e_wes, e_pat);
        op = c_op; src = c_src; dst = c_dst; len = c_len; fill_val = c_fill; start = 1'b1;
        @(posedge CLK);
        k = 0; seen = 1'b0; wes = 0; pat = '0;
        while (!seen && k < 600) begin
            @(negedge CLK);
            k++;
            if (k == 1) begin
                start = 1'b0;
                check("busy_after_start", 64'(busy), 64'd1);
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                if (WE) wes++;
                if (k - 1 < 32) pat[k-1] = WE;
            end
            if (poke && k == 2) begin
                op = 2'd0; dst = 32'd0; len = 16'd5; fill_val = 32'hDEAD_BEEF; start = 1'b1;
            end
            if (poke && k == 3) start = 1'b0;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(k), 64'(e_lat));
        check("err", 64'(err), 64'(e_err));
        check("sum", 64'(sum), 64'(e_sum));
        check("we_count", 64'(wes), 64'(e_wes));
        check("we_pattern", 64'(pat), 64'(e_pat));
        @(negedge CLK);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_dropped", 64'(busy), 64'd0);
        check("err_held", 64'(err), 64'(e_err));
        check("sum_held", 64'(sum), 64'(e_sum));
        compare_mem("memory");
    endtask

    initial begin
        logic [31:0] r;
        for (int k = 0; k < DEPTH; k++) begin
            r = $urandom;
            mem[wi(k)] = r;
            ref_mem[wi(k)] = r;
        end
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_A", 64'(A), 64'd0);
        check("rst_WD", 64'(WD), 64'd0);
        check("rst_WE", 64'(WE), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_cmd(2'd0, 32'd0, 32'd10, 16'd4, 32'hA5A5_A5A5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mem[wi(k)] = 32'(k + 1);
            ref_mem[wi(k)] = 32'(k + 1);
        end
        run_cmd(2'd1, 32'd0, 32'd50, 16'd3, 32'd0, 1'b0);
        run_cmd(2'd2, 32'd0, 32'd0, 16'd3, 32'd0, 1'b0);
        mem[0] = 32'hFFFF_FFFF; ref_mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'd2;         ref_mem[1] = 32'd2;
        run_cmd(2'd2, 32'd0, 32'd0, 16'd2, 32'd0, 1'b0);
        run_cmd(2'd0, 32'd0, 32'd98, 16'd3, 32'h1234_5678, 1'b0);
        run_cmd(2'd0, 32'd0, 32'd5, 16'd0, 32'h1234_5678, 1'b0);
        run_cmd(2'd0, 32'd0, 32'd96, 16'd4, 32'h0BAD_F00D, 1'b0);
        run_cmd(2'd0, 32'd0, 32'hFFFF_FFFF, 16'd2, 32'h0, 1'b0);
        run_cmd(2'd1, 32'd97, 32'd0, 16'd4, 32'h0, 1'b0);
        run_cmd(2'd1, 32'd10, 32'd12, 16'd5, 32'h0, 1'b1);
        run_cmd(2'd3, 32'd0, 32'd0, 16'd2, 32'h0, 1'b0);
        run_cmd(2'd2, 32'd1, 32'd0, 16'd4, 32'h0, 1'b0);

        // Reset asserted during the second FILL write: that write lands, later ones do not.
        op = 2'd0; dst = 32'd20; len = 16'd6; fill_val = 32'h5EED_0001; start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_WE", 64'(WE), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        ref_mem[20] = 32'h5EED_0001;
        ref_mem[21] = 32'h5EED_0001;
        compare_mem("rst_mid_memory");

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  r_op = 2'($urandom_range(0, 3));
            logic [31:0] r_src = 32'($urandom_range(0, 105));
            logic [31:0] r_dst = 32'($urandom_range(0, 105));
            logic [15:0] r_len = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 120))
                                                              : 16'($urandom_range(0, 12));
            run_cmd(r_op, r_src, r_dst, r_len, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
